// File: rtl/adaboost_pkg.sv
// Shared sizing, FSM state encoding and datapath types for the AdaBoost stream loader.
package adaboost_pkg;

  localparam int NFEAT = 30;
  localparam int WW    = 9;
  localparam int AW    = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_STREAM,
    S_WAIT,
    S_DONE
  } state_e;

  typedef logic signed [WW-1:0] weight_t;
  typedef logic signed [1:0]    data_t;

endpackage

// File: rtl/adaboost_weight_ram.sv
// Per-classifier weight store: one write port, one registered read port, no reset on contents.
module adaboost_weight_ram #(
  parameter int DEPTH = 30,
  parameter int W     = 9,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/adaboost_stream_loader.sv
// Sequences weight load, feature streaming and result collection for three AdaBoost classifiers.
module adaboost_stream_loader
  import adaboost_pkg::*;
#(
  parameter int NFEAT = adaboost_pkg::NFEAT,
  parameter int WW    = adaboost_pkg::WW,
  parameter int TMO   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_sel,
  input  logic [4:0]           cfg_addr,
  input  logic signed [WW-1:0] cfg_data,
  input  logic                 start,
  input  logic [NFEAT-1:0]     feature_vec,
  input  logic                 total_ready,
  input  logic signed [1:0]    total_predict,
  output logic                 write1,
  output logic                 write2,
  output logic                 write3,
  output logic signed [WW-1:0] weight1,
  output logic signed [WW-1:0] weight2,
  output logic signed [WW-1:0] weight3,
  output logic                 read1,
  output logic                 read2,
  output logic                 read3,
  output logic                 en,
  output data_t                data1,
  output data_t                data2,
  output data_t                data3,
  output logic [4:0]           address,
  output logic                 busy,
  output logic                 res_valid,
  output logic signed [1:0]    res,
  output logic                 timeout
);

  localparam int CW = $clog2(TMO + 1);
  localparam logic [AW-1:0] LAST    = AW'(NFEAT - 1);
  localparam logic [CW-1:0] CNT_END = CW'(TMO - 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NFEAT-1:0]  vec_q, vec_d;
  logic signed [1:0] res_q, res_d;
  logic              tmo_q, tmo_d;
  logic              cfg_ok;
  logic [WW-1:0]     rdata [3];

  assign cfg_ok = cfg_we && (state_q == S_IDLE) && (cfg_sel != 2'd0)
                  && (int'(cfg_addr) < NFEAT);

  // Read address is the next-cycle index so the registered read lines up with address.
  for (genvar g = 0; g < 3; g++) begin : g_ram
    adaboost_weight_ram #(
      .DEPTH (NFEAT),
      .W     (WW),
      .AW    (AW)
    ) u_ram (
      .clk     (clk),
      .we_i    (cfg_ok && (cfg_sel == 2'(g + 1))),
      .waddr_i (cfg_addr),
      .wdata_i (cfg_data),
      .raddr_i (addr_d),
      .rdata_o (rdata[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      vec_q   <= '0;
      res_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      res_q   <= res_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    res_d   = res_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        vec_d   = feature_vec;
        addr_d  = '0;
        res_d   = '0;
        tmo_d   = 1'b0;
        state_d = S_LOAD;
      end
      S_LOAD: if (addr_q == LAST) begin
        addr_d  = '0;
        state_d = S_ARM;
      end else begin
        addr_d = addr_q + 1'b1;
      end
      S_ARM: state_d = S_STREAM;
      S_STREAM: if (addr_q == LAST) begin
        addr_d  = '0;
        cnt_d   = '0;
        state_d = S_WAIT;
      end else begin
        addr_d = addr_q + 1'b1;
      end
      S_WAIT: if (total_ready) begin
        res_d   = total_predict;
        state_d = S_DONE;
      end else if (cnt_q == CNT_END) begin
        res_d   = '0;
        tmo_d   = 1'b1;
        state_d = S_DONE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    write1    = (state_q == S_LOAD);
    write2    = write1;
    write3    = write1;
    weight1   = write1 ? rdata[0] : '0;
    weight2   = write1 ? rdata[1] : '0;
    weight3   = write1 ? rdata[2] : '0;
    read1     = (state_q == S_ARM) || (state_q == S_STREAM);
    read2     = read1;
    read3     = read1;
    en        = (state_q == S_STREAM);
    data1     = en ? {1'b0, vec_q[addr_q]} : '0;
    data2     = data1;
    data3     = data1;
    address   = addr_q;
    busy      = (state_q != S_IDLE);
    res_valid = (state_q == S_DONE);
    res       = res_q;
    timeout   = tmo_q;
  end

endmodule
